// File: rtl/tlb_search_arbiter.sv
// rtl/tlb_search_arbiter.sv - shares one TLB search port between inst-side and data-side requesters
// Define TLB_ARB_RR_EN for round-robin arbitration; otherwise data side has fixed priority.
module tlb_search_arbiter #(
  parameter int VPN2_W = 19,
  parameter int PFN_W  = 20,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [VPN2_W-1:0] i_vpn2,
  input  logic              i_odd,
  output logic              i_ack,
  input  logic              i_cancel,
  output logic              i_resp_valid,
  input  logic              d_req,
  input  logic [VPN2_W-1:0] d_vpn2,
  input  logic              d_odd,
  output logic              d_ack,
  input  logic              d_cancel,
  output logic              d_resp_valid,
  output logic              resp_found,
  output logic [IDX_W-1:0]  resp_index,
  output logic [PFN_W-1:0]  resp_pfn,
  output logic [2:0]        resp_c,
  output logic              resp_d,
  output logic              resp_v,
  input  logic [31:0]       cp0_entryhi,
  input  logic              tlb_write,
  output logic [VPN2_W-1:0] s_vpn2,
  output logic              s_odd_page,
  output logic [7:0]        s_asid,
  input  logic              s_found,
  input  logic [IDX_W-1:0]  s_index,
  input  logic [PFN_W-1:0]  s_pfn,
  input  logic [2:0]        s_c,
  input  logic              s_d,
  input  logic              s_v,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t state, state_next;
  logic   owner;            // 1 = data side owns the transaction
  logic   i_ok, d_ok, grant, grant_d, prefer_d, owner_cancel, capture;
  logic   unused_entryhi;

  assign unused_entryhi = ^cp0_entryhi[31:8];

`ifdef TLB_ARB_RR_EN
  logic last_grant;         // 1 = data side won the previous grant

  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= 1'b0;
    else if (grant)
      last_grant <= grant_d;
  end

  assign prefer_d = ~last_grant;
`else
  assign prefer_d = 1'b1;
`endif

  always_comb begin
    i_ok         = i_req & ~i_cancel;
    d_ok         = d_req & ~d_cancel;
    grant        = (state == IDLE) & ~reset & ~tlb_write & (i_ok | d_ok);
    grant_d      = d_ok & (prefer_d | ~i_ok);
    owner_cancel = owner ? d_cancel : i_cancel;
    capture      = (state == LOOKUP) & ~owner_cancel & ~tlb_write;
  end

  always_comb begin
    state_next   = state;
    i_ack        = 1'b0;
    d_ack        = 1'b0;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    case (state)
      IDLE: begin
        i_ack = grant & ~grant_d;
        d_ack = grant & grant_d;
        if (grant)
          state_next = LOOKUP;
      end
      LOOKUP: begin
        // a write in progress stalls the search; it is replayed once the write drops
        if (owner_cancel)
          state_next = IDLE;
        else if (!tlb_write)
          state_next = RESP;
      end
      RESP: begin
        i_resp_valid = ~owner & ~i_cancel;
        d_resp_valid = owner & ~d_cancel;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      s_vpn2     <= '0;
      s_odd_page <= 1'b0;
      s_asid     <= 8'h00;
      resp_found <= 1'b0;
      resp_index <= '0;
      resp_pfn   <= '0;
      resp_c     <= 3'b000;
      resp_d     <= 1'b0;
      resp_v     <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        owner      <= grant_d;
        s_vpn2     <= grant_d ? d_vpn2 : i_vpn2;
        s_odd_page <= grant_d ? d_odd : i_odd;
        s_asid     <= cp0_entryhi[7:0];
      end
      if (capture) begin
        resp_found <= s_found;
        resp_index <= s_index;
        resp_pfn   <= s_pfn;
        resp_c     <= s_c;
        resp_d     <= s_d;
        resp_v     <= s_v;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/tlb_search_arbiter.md
Name: tlb_search_arbiter

Overview:
Shares the single TLB search port between two requesters: the instruction-side TLB cache miss path (requester I) and the data-side memory-stage lookup (requester D). Each request is registered, the TLB is searched in a dedicated cycle, and the registered result is returned to the owning requester. Lookups are held off while a TLB write is in progress. Per-requester cancels handle pipeline flushes.

Parameters:
VPN2_W, 19, virtual page number (pair) width
PFN_W, 20, physical frame number width
IDX_W, 4, TLB index width (16 entries)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_req  in  1  inst-side lookup request; held until i_ack
i_vpn2  in  VPN2_W  inst VA[31:13]
i_odd  in  1  inst VA[12]
i_ack  out  1  inst request accepted this cycle (combinational)
i_cancel  in  1  inst flush; drops an inst request that is in flight
i_resp_valid  out  1  one-cycle pulse: result for inst request
d_req  in  1  data-side lookup request; held until d_ack
d_vpn2  in  VPN2_W  data VA[31:13]
d_odd  in  1  data VA[12]
d_ack  out  1  data request accepted this cycle (combinational)
d_cancel  in  1  data flush; drops a data request that is in flight
d_resp_valid  out  1  one-cycle pulse: result for data request
resp_found  out  1  registered hit flag
resp_index  out  IDX_W  registered hit index
resp_pfn  out  PFN_W  registered PFN
resp_c  out  3  registered cache attribute
resp_d  out  1  registered dirty bit
resp_v  out  1  registered valid bit
cp0_entryhi  in  32  ASID source, bits [7:0]
tlb_write  in  1  TLBWI/TLBWR in progress
s_vpn2  out  VPN2_W  search port VPN2
s_odd_page  out  1  search port odd-page bit
s_asid  out  8  search port ASID
s_found, s_index, s_pfn, s_c, s_d, s_v  in  1/IDX_W/PFN_W/3/1/1  combinational TLB search result
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LOOKUP, RESP. Reset (synchronous) sets state=IDLE, owner=0, last_grant=I, and clears all registered outputs. At reset: i_ack=d_ack=0, resp_*=0, s_*=0, busy=0.
- IDLE: a grant happens only if tlb_write=0 and (i_req|d_req).
  - Default arbitration is fixed priority, D over I.
  - The winner's ack is 1 in that cycle. The arbiter latches vpn2, odd and cp0_entryhi[7:0] into req regs and records owner. Next state is LOOKUP.
  - A requester whose cancel is high in the same cycle is not granted.
- s_vpn2/s_odd_page/s_asid are driven from req regs only; they never come combinationally from inputs.
- LOOKUP:
  - If tlb_write=1, stay in LOOKUP and discard the search result. The lookup is replayed once tlb_write drops.
  - Otherwise, capture s_* into resp_* and go to RESP.
- RESP: assert owner's resp_valid for exactly one cycle, then go to IDLE. A new grant is possible in the next cycle (IDLE), not in the same cycle.
- Latency: ack at cycle T, resp_valid at T+2 (absent tlb_write). Throughput is one lookup per 3 cycles.
- Cancel: if the owner's cancel is high in LOOKUP or RESP, suppress resp_valid and go to IDLE next cycle. Cancel of the non-owner has no effect on the current transaction.
- resp_* hold their last captured value until the next capture; they are not cleared on cancel.
- i_resp_valid and d_resp_valid are never high together. resp_valid never fires without a prior ack.
- Reset mid-transaction aborts with no resp_valid.

Optional Feature:
Macro TLB_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are high in IDLE, grant the one not in last_grant. last_grant updates on every grant. A single requester is always granted.
- Undefined: fixed priority D over I, and the last_grant register is not built.

Test Plan:
- Single request: d_req=1 with d_vpn2=19'h00123, d_odd=1 and entryhi[7:0]=8'h5A. Expect d_ack at T; s_vpn2=19'h00123, s_odd_page=1 and s_asid=8'h5A at T+1. With model s_found=1, s_pfn=20'h0ABCD: d_resp_valid=1 at T+2 with resp_pfn=20'h0ABCD, then busy=0 at T+3.
- Contention: i_req and d_req both high continuously. Fixed mode: grant order D, D, D. With TLB_ARB_RR_EN: order D, I, D, I, with i_resp_valid and d_resp_valid alternating every 3 cycles.
- tlb_write: tlb_write=1 in IDLE with i_req=1 → no i_ack until tlb_write=0. tlb_write=1 for 2 cycles during LOOKUP → resp_valid delayed 2 cycles; resp_* reflect the post-write TLB contents.
- Cancel: grant I at T, then i_cancel=1 at T+1 → no i_resp_valid; state returns to IDLE at T+2. d_cancel=1 at T+1 during an inst transaction → i_resp_valid still at T+2.
- Miss: s_found=0 → resp_valid pulses with resp_found=0.
- Reset: assert reset in LOOKUP → next cycle busy=0, resp_*=0, and no resp_valid.
